// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
// Optional trailing checksum state is present only when LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_RX_WORD,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_RX_CSUM
`endif
  } loader_state_t;

endpackage

// File: rtl/mips_program_loader_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the
// byte that completes a word.
module word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_valid) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = byte_valid && !clear && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_program_loader.sv
// Loads a length-prefixed byte-stream program image into instruction memory
// and holds the CPU in reset until done. Optional: LOADER_CHECKSUM_EN.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  loader_state_t            state_q, state_d;
  logic [LEN_BYTES*8-1:0]   len_q, len_d;
  logic [15:0]              word_idx_q, word_idx_d;
  logic [LEN_BYTES*8-1:0]   len_next;
  logic [15:0]              word_idx_inc;
  logic                     rx_fire;
  logic                     packer_clear;
  logic                     packer_valid;
  logic [31:0]              packed_word;
  logic                     word_complete;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif

  assign rx_fire      = rx_valid && rx_ready;
  assign len_next     = {len_q[LEN_BYTES*8-9:0], rx_data};
  assign word_idx_inc = word_idx_q + 16'd1;
  assign packer_valid = rx_fire && (state_q == S_RX_WORD);

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (packer_clear),
    .byte_valid (packer_valid),
    .byte_in    (rx_data),
    .word       (packed_word),
    .word_valid (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    packer_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = rx_fire ? (csum_q ^ rx_data) : csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          word_idx_d   = '0;
          packer_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (rx_fire) begin
          len_d   = len_next;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_fire) begin
          len_d      = len_next;
          word_idx_d = '0;
          if (len_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_RX_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if (32'(len_next) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RX_WORD;
          end
        end
      end
      S_RX_WORD: begin
        if (word_complete) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (word_idx_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_RX_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          word_idx_d = word_idx_inc;
          state_d    = S_RX_WORD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_RX_CSUM: begin
        if (rx_fire) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_LEN_HI, S_LEN_LO, S_RX_WORD: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_RX_CSUM: rx_ready = 1'b1;
`endif
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = START_ADDR + {14'b0, word_idx_q, 2'b00};
        mem_wdata = packed_word;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed self-checking bench for mips_program_loader (default parameters).
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_cpurst[$];
  int          ready_viol = 0;

  mips_program_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cpurst.push_back(cpu_reset);
      if (rx_ready) ready_viol++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: rx_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask

  task automatic send_image(input logic [15:0] n, input logic [31:0] w[$], input int gap);
    logic [7:0] q[$];
    logic [7:0] x;
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    foreach (w[i]) begin
      q.push_back(w[i][31:24]); q.push_back(w[i][23:16]);
      q.push_back(w[i][15:8]);  q.push_back(w[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`else
    x = 8'h00;
`endif
    send_bytes(q, gap);
  endtask

  task automatic wait_end(input int bound);
    int t = 0;
    @(negedge clk);
    while (!(done || error) && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) begin
      n_cmp++; n_err++;
      $display("FAIL end_timeout: done=%0b error=%0b, required one of them 1", done, error);
    end
  endtask

  task automatic check_basic_writes(input string tag, input int base);
    n_cmp++; if (wr_addr.size() - base !== 2) begin n_err++; $display("FAIL %s_write_count: got %0d required 2", tag, wr_addr.size() - base); end
    n_cmp++; if (wr_addr[base] !== 32'h0) begin n_err++; $display("FAIL %s_addr0: got %h required 00000000", tag, wr_addr[base]); end
    n_cmp++; if (wr_data[base] !== 32'h20080005) begin n_err++; $display("FAIL %s_data0: got %h required 20080005", tag, wr_data[base]); end
    n_cmp++; if (wr_addr[base+1] !== 32'h4) begin n_err++; $display("FAIL %s_addr1: got %h required 00000004", tag, wr_addr[base+1]); end
    n_cmp++; if (wr_data[base+1] !== 32'h8C090004) begin n_err++; $display("FAIL %s_data1: got %h required 8c090004", tag, wr_data[base+1]); end
    n_cmp++; if (wr_cpurst[base+1] !== 1'b1) begin n_err++; $display("FAIL %s_cpurst_in_write: got %b required 1", tag, wr_cpurst[base+1]); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done: got %b required 1", tag, done); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL %s_cpu_reset: got %b required 0", tag, cpu_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b required 0", tag, busy); end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL %s_rx_ready: got %b required 0", tag, rx_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL %s_mem_we: got %b required 0", tag, mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL %s_mem_addr: got %h required 0", tag, mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL %s_mem_wdata: got %h required 0", tag, mem_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b required 0", tag, busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done: got %b required 0", tag, done); end
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL %s_error: got %b required 0", tag, error); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL %s_cpu_reset: got %b required 1", tag, cpu_reset); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    logic [31:0] img[$];
    int base = wr_addr.size();
    img = '{32'h20080005, 32'h8C090004};
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start: got %b required 1", busy); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_len: got %b required 1", rx_ready); end
    send_image(16'd2, img, 0);
    wait_end(20);
    check_basic_writes("basic", base);
  endtask

  task automatic test_gapped_load();
    logic [31:0] img[$];
    int base = wr_addr.size();
    int viol0 = ready_viol;
    img = '{32'h20080005, 32'h8C090004};
    pulse_start();
    n_cmp++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL reload_cpu_reset_done: got %b/%b required 1/0", cpu_reset, done); end
    send_image(16'd2, img, 1);
    wait_end(20);
    check_basic_writes("gapped", base);
    n_cmp++; if (ready_viol - viol0 !== 0) begin n_err++; $display("FAIL gapped_ready_in_write: got %0d required 0", ready_viol - viol0); end
  endtask

  task automatic test_empty();
    logic [7:0] q[$];
    int base = wr_addr.size();
`ifdef LOADER_CHECKSUM_EN
    q = '{8'h00, 8'h00, 8'h00};
`else
    q = '{8'h00, 8'h00};
`endif
    pulse_start();
    send_bytes(q, 0);
    @(negedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %b required 1", done); end
    n_cmp++; if (wr_addr.size() - base !== 0) begin n_err++; $display("FAIL empty_writes: got %0d required 0", wr_addr.size() - base); end
  endtask

  task automatic test_overflow();
    logic [7:0]  q[$];
    logic [31:0] img[$];
    int base = wr_addr.size();
    q = '{8'h01, 8'h01};
    pulse_start();
    send_bytes(q, 0);
    @(negedge clk); @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL ovf_error: got %b required 1", error); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL ovf_cpu_reset: got %b required 1", cpu_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy: got %b required 0", busy); end
    n_cmp++; if (wr_addr.size() - base !== 0) begin n_err++; $display("FAIL ovf_writes: got %0d required 0", wr_addr.size() - base); end
    img = '{32'h12345678};
    pulse_start();
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL ovf_error_cleared: got %b required 0", error); end
    send_image(16'd1, img, 0);
    wait_end(20);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ovf_reload_done: got %b required 1", done); end
    n_cmp++; if (wr_addr.size() - base !== 1) begin n_err++; $display("FAIL ovf_reload_writes: got %0d required 1", wr_addr.size() - base); end
    n_cmp++; if (wr_data[base] !== 32'h12345678) begin n_err++; $display("FAIL ovf_reload_data: got %h required 12345678", wr_data[base]); end
  endtask

  task automatic test_reset_mid_session();
    logic [7:0]  q[$];
    logic [31:0] img[$];
    int base;
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    pulse_start();
    send_bytes(q, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    reset = 1'b0;
    @(posedge clk); #1;
    base = wr_addr.size();
    img = '{32'h20080005, 32'h8C090004};
    pulse_start();
    send_image(16'd2, img, 0);
    wait_end(20);
    check_basic_writes("midrst_reload", base);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] q[$];
    int base = wr_addr.size();
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    pulse_start();
    send_bytes(q, 0);
    wait_end(20);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL csum_good_done: got %b required 1", done); end
    base = wr_addr.size();
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    pulse_start();
    send_bytes(q, 0);
    wait_end(20);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL csum_bad_error: got %b required 1", error); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL csum_bad_cpu_reset: got %b required 1", cpu_reset); end
    n_cmp++; if (wr_addr.size() - base !== 1) begin n_err++; $display("FAIL csum_bad_writes: got %0d required 1", wr_addr.size() - base); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_empty();
    test_overflow();
    test_reset_mid_session();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
